// File: rtl/dpram_pkg.sv
// dpram_pkg
//   Shared definitions for the dpram_bwe scratchpad RAM:
//   - clear-sequencer state encoding
//   - read-during-write mode constants
//   - byte-granular merge helper
// The merge helper works on a fixed maximum word width so it can serve any
// DATA_WIDTH up to MAX_DW; callers widen their operands and narrow the result.
package dpram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RDW_NEW = 0;
    localparam int RDW_OLD = 1;

    localparam int MAX_DW = 1024;

    typedef logic [MAX_DW-1:0]   word_t;
    typedef logic [MAX_DW/8-1:0] be_t;

    // Returns old_w with every byte whose enable bit is set replaced by new_w.
    function automatic word_t byte_merge(input word_t old_w, input word_t new_w, input be_t be);
        word_t res;
        res = old_w;
        for (int i = 0; i < MAX_DW/8; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_out_stage.sv
// dpram_out_stage
//   Read-data output register for one RAM port, with an optional second stage.
//   The first stage captures the word read on the accepting edge; with
//   OUT_REG=1 a second stage adds one cycle of latency. Data registers only
//   load when their valid bit is set, so dout holds between strobes.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset; drops everything in flight
//   acc    in   an access was accepted this cycle
//   rdata  in   word to return for that access
//   dout   out  registered read data
//   dvld   out  one-cycle strobe per accepted access
module dpram_out_stage #(
    parameter int DATA_WIDTH = 128,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvld
);

    logic [DATA_WIDTH-1:0] data_s0;
    logic                  vld_s0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_s0 <= '0;
            vld_s0  <= 1'b0;
        end else begin
            vld_s0 <= acc;
            if (acc) begin
                data_s0 <= rdata;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] data_s1;
            logic                  vld_s1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_s1 <= '0;
                    vld_s1  <= 1'b0;
                end else begin
                    vld_s1 <= vld_s0;
                    if (vld_s0) begin
                        data_s1 <= data_s0;
                    end
                end
            end

            assign dout = data_s1;
            assign dvld = vld_s1;
        end else begin : g_no_out_reg
            assign dout = data_s0;
            assign dvld = vld_s0;
        end
    endgenerate

endmodule

// File: rtl/dpram_bwe.sv
// dpram_bwe
//   Symmetric dual-port RAM with per-byte write enables, selectable
//   read-during-write result, optional output register, cross-port collision
//   pulse and a hardware clear sequencer.
//
//   Optional feature macro: DPRAM_INIT_CLEAR_EN
//     defined   : clear sequencer present; array zeroed after reset and on clr
//     undefined : always in RUN, init_busy tied low, clr ignored, array
//                 contents undefined after reset
//
//   Clear sequencer states:
//     state    | meaning
//     ST_CLEAR | zeroing two words per cycle, user accesses ignored
//     ST_RUN   | normal operation, user accesses accepted
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   clr          in   pulse in RUN restarts the clear sequence
//   init_busy    out  high while the clear sequence runs
//   en1/en2      in   port access enable
//   we1/we2      in   write (1) / read (0)
//   be1/be2      in   byte write enables
//   addr1/addr2  in   word address
//   din1/din2    in   write data
//   dout1/dout2  out  read data
//   dvld1/dvld2  out  read data valid strobe
//   collision    out  same-address access with at least one write, one cycle
module dpram_bwe
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int BE_WIDTH   = DATA_WIDTH/8,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  init_busy,
    input  logic                  en1,
    input  logic                  en2,
    input  logic                  we1,
    input  logic                  we2,
    input  logic [BE_WIDTH-1:0]   be1,
    input  logic [BE_WIDTH-1:0]   be2,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] dout2,
    output logic                  dvld1,
    output logic                  dvld2,
    output logic                  collision
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CNT_W = (ADDR_WIDTH > 1) ? ADDR_WIDTH-1 : 1;

    function automatic logic [DATA_WIDTH-1:0] merge_w(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_WIDTH-1:0]   be
    );
        return DATA_WIDTH'(byte_merge(word_t'(old_w), word_t'(new_w), be_t'(be)));
    endfunction

    logic                  run;
    logic [ADDR_WIDTH-1:0] clr_addr1;
    logic [ADDR_WIDTH-1:0] clr_addr2;

`ifdef DPRAM_INIT_CLEAR_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEPTH/2) - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign run       = (state_q == ST_RUN);
    assign init_busy = ~run;

    // Port 1 clears the even word and port 2 the odd word of each pair; with a
    // single address bit the truncation leaves exactly addresses 0 and 1.
    assign clr_addr1 = ADDR_WIDTH'({cnt_q, 1'b0});
    assign clr_addr2 = ADDR_WIDTH'({cnt_q, 1'b1});
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign run        = 1'b1;
    assign init_busy  = 1'b0;
    assign clr_addr1  = '0;
    assign clr_addr2  = '0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc1;
    logic                  acc2;
    logic                  wr1;
    logic                  wr2;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] old1;
    logic [DATA_WIDTH-1:0] old2;
    logic [DATA_WIDTH-1:0] merged1;
    logic [DATA_WIDTH-1:0] merged2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;

    logic                  wen1;
    logic                  wen2;
    logic [ADDR_WIDTH-1:0] waddr1;
    logic [ADDR_WIDTH-1:0] waddr2;
    logic [DATA_WIDTH-1:0] wdata1;
    logic [DATA_WIDTH-1:0] wdata2;

    assign acc1      = en1 & run;
    assign acc2      = en2 & run;
    assign wr1       = acc1 & we1;
    assign wr2       = acc2 & we2;
    assign same_addr = (addr1 == addr2);

    assign old1    = mem[addr1];
    assign old2    = mem[addr2];
    assign merged1 = merge_w(old1, din1, be1);
    assign merged2 = merge_w(old2, din2, be2);

    // When both ports write one word, port 2 carries the combined result
    // (port 1 bytes first, port 2 bytes on top) and port 1 stays idle, so a
    // single write lands and port 2 wins on overlapping bytes.
    always_comb begin
        wen1   = 1'b0;
        wen2   = 1'b0;
        waddr1 = addr1;
        waddr2 = addr2;
        wdata1 = merged1;
        wdata2 = merged2;
        if (!run) begin
            wen1   = 1'b1;
            wen2   = 1'b1;
            waddr1 = clr_addr1;
            waddr2 = clr_addr2;
            wdata1 = '0;
            wdata2 = '0;
        end else begin
            wen1 = wr1 & ~(wr2 & same_addr);
            wen2 = wr2;
            if (wr1 & same_addr) begin
                wdata2 = merge_w(merged1, din2, be2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wen1) begin
            mem[waddr1] <= wdata1;
        end
        if (wen2) begin
            mem[waddr2] <= wdata2;
        end
    end

    // A writing port in new-data mode returns its own merge against the
    // pre-write word; a reading port always sees the pre-write word.
    assign rdata1 = (wr1 && (RDW_MODE == RDW_NEW)) ? merged1 : old1;
    assign rdata2 = (wr2 && (RDW_MODE == RDW_NEW)) ? merged2 : old2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision <= 1'b0;
        end else begin
            collision <= acc1 & acc2 & same_addr & (we1 | we2);
        end
    end

    dpram_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_out1 (
        .clk   (clk),
        .rst   (rst),
        .acc   (acc1),
        .rdata (rdata1),
        .dout  (dout1),
        .dvld  (dvld1)
    );

    dpram_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_out2 (
        .clk   (clk),
        .rst   (rst),
        .acc   (acc2),
        .rdata (rdata2),
        .dout  (dout2),
        .dvld  (dvld2)
    );

endmodule

// File: tb/tb_dpram_bwe.sv
// tb_dpram_bwe
//   Drives two dpram_bwe instances with identical stimulus:
//     dut 0 : OUT_REG=0, RDW_MODE=0 (latency 1, new data)
//     dut 1 : OUT_REG=1, RDW_MODE=1 (latency 2, old data)
//   A word-level model of the array predicts every output each cycle; a few
//   literal expectations pin the model to hand-computed values.
module tb_dpram_bwe;

    localparam int DW    = 128;
    localparam int AW    = 6;
    localparam int BW    = DW/8;
    localparam int DEPTH = 2**AW;
`ifdef DPRAM_INIT_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          en1, en2, we1, we2;
    logic [BW-1:0] be1, be2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] din1, din2;

    logic [DW-1:0] dout1 [2];
    logic [DW-1:0] dout2 [2];
    logic          dvld1 [2];
    logic          dvld2 [2];
    logic          coll  [2];
    logic          busy  [2];

    always #5 clk = ~clk;

    dpram_bwe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .init_busy(busy[0]),
        .en1(en1), .en2(en2), .we1(we1), .we2(we2), .be1(be1), .be2(be2),
        .addr1(addr1), .addr2(addr2), .din1(din1), .din2(din2),
        .dout1(dout1[0]), .dout2(dout2[0]), .dvld1(dvld1[0]), .dvld2(dvld2[0]),
        .collision(coll[0])
    );

    dpram_bwe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .init_busy(busy[1]),
        .en1(en1), .en2(en2), .we1(we1), .we2(we2), .be1(be1), .be2(be2),
        .addr1(addr1), .addr2(addr2), .din1(din1), .din2(din2),
        .dout1(dout1[1]), .dout2(dout2[1]), .dvld1(dvld1[1]), .dvld2(dvld2[1]),
        .collision(coll[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] bmerge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                             input logic [BW-1:0] b);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < BW; i++) begin
            if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mm [DEPTH];
    int            clear_left;
    int            cyc = 0;
    bit            checking = 1'b0;
    // outputs scheduled by the cycle they become visible, ring of 4 cycles
    logic          sv [2][2][4];
    logic [DW-1:0] sd [2][2][4];
    logic          csched [4];
    logic [DW-1:0] last [2][2];
    bit            count_en = 1'b0;
    int            vcount = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                last[d][p] = '0;
                for (int s = 0; s < 4; s++) sv[d][p][s] = 1'b0;
            end
        for (int s = 0; s < 4; s++) csched[s] = 1'b0;
        clear_left = CLR_EN ? DEPTH/2 : 0;
        if (CLR_EN) for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = CLR_EN ? '0 : 'x;
        model_reset();
    end

    always @(posedge clk) begin : model
        logic [DW-1:0] o1, o2, n1, n2;
        int s0, s1;
        cyc = cyc + 1;
        s0 = cyc % 4;
        s1 = (cyc + 1) % 4;
        if (rst) begin
            model_reset();
        end else if (clear_left == 0) begin
            o1 = mm[addr1];
            o2 = mm[addr2];
            n1 = bmerge(o1, din1, be1);
            n2 = bmerge(o2, din2, be2);
            if (en1) begin
                sv[0][0][s0] = 1'b1; sd[0][0][s0] = we1 ? n1 : o1;
                sv[1][0][s1] = 1'b1; sd[1][0][s1] = o1;
            end
            if (en2) begin
                sv[0][1][s0] = 1'b1; sd[0][1][s0] = we2 ? n2 : o2;
                sv[1][1][s1] = 1'b1; sd[1][1][s1] = o2;
            end
            if (en1 && en2 && addr1 == addr2 && (we1 || we2)) csched[s0] = 1'b1;
            if (en1 && we1) mm[addr1] = n1;
            // applied after port 1 so port 2 owns bytes both ports enable
            if (en2 && we2) mm[addr2] = bmerge(mm[addr2], din2, be2);
            if (CLR_EN && clr) begin
                clear_left = DEPTH/2;
                for (int i = 0; i < DEPTH; i++) mm[i] = '0;
            end
        end else begin
            clear_left = clear_left - 1;
        end
    end

    always @(negedge clk) begin : compare
        int s;
        logic av;
        logic [DW-1:0] ad;
        if (checking) begin
            s = cyc % 4;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    av = (p == 0) ? dvld1[d] : dvld2[d];
                    ad = (p == 0) ? dout1[d] : dout2[d];
                    if (sv[d][p][s]) last[d][p] = sd[d][p][s];
                    check($sformatf("dut%0d.dvld%0d", d, p+1), DW'(av), DW'(sv[d][p][s]));
                    check($sformatf("dut%0d.dout%0d", d, p+1), ad, last[d][p]);
                    sv[d][p][s] = 1'b0;
                end
                check($sformatf("dut%0d.collision", d), DW'(coll[d]), DW'(csched[s]));
                check($sformatf("dut%0d.init_busy", d), DW'(busy[d]), DW'(clear_left > 0));
            end
            csched[s] = 1'b0;
            if (count_en) vcount += int'(dvld1[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        en1 = 1'b0; en2 = 1'b0; we1 = 1'b0; we2 = 1'b0; clr = 1'b0;
        be1 = '0; be2 = '0;
    endtask

    task automatic port1(input logic w, input logic [BW-1:0] b, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        en1 = 1'b1; we1 = w; be1 = b; addr1 = a; din1 = d;
    endtask

    task automatic port2(input logic w, input logic [BW-1:0] b, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        en2 = 1'b1; we2 = w; be2 = b; addr2 = a; din2 = d;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] ones;
        ones = '1;
        rst = 1'b1;
        idle();
        addr1 = '0; addr2 = '0; din1 = '0; din2 = '0;
        tick();
        checking = 1'b1;
        tick();
        check("reset init_busy", DW'(busy[0]), DW'(CLR_EN));
        check("reset dout1", dout1[0], '0);
        tick();
        rst = 1'b0;

`ifdef DPRAM_INIT_CLEAR_EN
        repeat (31) tick();
        check("busy at clear cycle 31", DW'(busy[0]), DW'(1));
        tick();
        check("busy after 32 cycles", DW'(busy[0]), DW'(0));
        for (int a = 0; a < DEPTH/2; a++) begin
            port1(1'b0, '0, AW'(2*a), '0);
            port2(1'b0, '0, AW'(2*a+1), '0);
            tick();
            if (a == 0) begin
                check("cleared word read", dout1[0], '0);
                check("cleared read dvld", DW'(dvld1[0]), DW'(1));
            end
        end
`else
        for (int a = 0; a < DEPTH/2; a++) begin
            port1(1'b1, '1, AW'(2*a), rnd_word());
            port2(1'b1, '1, AW'(2*a+1), rnd_word());
            tick();
        end
`endif
        idle(); tick(); tick();

        // byte-enable write
        port1(1'b1, '1, 6'd5, ones); tick();
        port1(1'b1, 16'h0001, 6'd5, {{120{1'b0}}, 8'hAB} | {8'h00, {15{8'h55}}, 8'h00}); tick();
        port1(1'b0, '0, 6'd5, '0); tick();
        check("be write addr5 dut0", dout1[0], {{120{1'b1}}, 8'hAB});
        idle(); tick();
        check("be write addr5 dut1", dout1[1], {{120{1'b1}}, 8'hAB});

        // read-during-write mode
        port1(1'b1, '1, 6'd3, {16{8'h11}}); tick();
        port1(1'b1, '1, 6'd3, {16{8'h22}}); tick();
        check("rdw new", dout1[0], {16{8'h22}});
        idle(); tick();
        check("rdw old", dout1[1], {16{8'h11}});

        // both ports write one word
        port1(1'b1, '1, 6'd7, '0); tick();
        port1(1'b1, 16'h00FF, 6'd7, {16{8'hAA}});
        port2(1'b1, 16'h0F0F, 6'd7, {16{8'hBB}});
        tick();
        check("collision pulse", DW'(coll[0]), DW'(1));
        idle(); tick();
        check("collision single", DW'(coll[0]), DW'(0));
        port1(1'b0, '0, 6'd7, '0); tick();
        check("dual write merge", dout1[0], 128'h00000000_BBBBBBBB_AAAAAAAA_BBBBBBBB);
        idle(); tick();

        // back-to-back reads on both ports
        count_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            port1(1'b0, '0, AW'(i), '0);
            port2(1'b0, '0, AW'(63 - i), '0);
            tick();
        end
        idle(); tick(); tick();
        count_en = 1'b0;
        check("streamed dvld count", DW'(vcount), DW'(16));

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                port1(1'($urandom), BW'($urandom), AW'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1)), rnd_word());
            if ($urandom_range(0, 3) != 0)
                port2(1'($urandom), BW'($urandom), AW'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1)), rnd_word());
            if ($urandom_range(0, 7) == 0) begin be1 = '1; be2 = '0; end
            clr = ($urandom_range(0, 79) == 0);
            tick();
        end
        idle();
        repeat (DEPTH/2 + 2) tick();

`ifdef DPRAM_INIT_CLEAR_EN
        // clear request with reads in flight
        port1(1'b1, '1, 6'd5, ones); tick();
        port1(1'b0, '0, 6'd5, '0);
        port2(1'b0, '0, 6'd5, '0);
        clr = 1'b1;
        tick();
        check("clr busy rises", DW'(busy[0]), DW'(1));
        check("pre-clr read dut0", dout1[0], ones);
        idle(); tick();
        check("pre-clr read dut1 dvld", DW'(dvld1[1]), DW'(1));
        repeat (10) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        repeat (31) tick();
        check("restarted clear busy", DW'(busy[0]), DW'(1));
        tick();
        check("restarted clear done", DW'(busy[0]), DW'(0));
        port1(1'b0, '0, 6'd5, '0); tick();
        check("post-clear read", dout1[0], '0);
        idle(); tick();
`endif

        // reset with a read in flight
        port1(1'b0, '0, 6'd3, '0); tick();
        idle();
        rst = 1'b1;
        tick();
        check("reset drops dvld", DW'(dvld1[1]), DW'(0));
        rst = 1'b0;
        repeat (CLR_EN ? DEPTH/2 + 2 : 2) tick();
        port1(1'b0, '0, 6'd3, '0); tick();
        idle(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
